dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl - data-memory controller between the core MEM stage and an
// on-chip 32-bit data RAM.
//
// Supports byte/halfword/word stores through byte lanes, and sign- or
// zero-extended loads. Requests and responses each use a valid/ready
// handshake. Only one request is outstanding at a time. A configurable
// number of wait states can be inserted before the RAM access.
//
// Parameters:
//   ADDR_W       byte-address width; RAM depth is 2**(ADDR_W-2) words
//   WAIT_CYCLES  extra cycles between request accept and RAM access (0..15)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst_n         synchronous active-low reset
//   req_valid     request present
//   req_ready     controller can accept a request (registered)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 treated as word
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   req_wdata     store data, right-aligned
//   rsp_valid     response present (registered)
//   rsp_ready     consumer accepts the response
//   rsp_rdata     load result, 0 for stores (registered)
//   rsp_err       misaligned access flag (registered)
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   Defined:   a misaligned half/word access is flagged with rsp_err=1. It
//              writes no lane, and a misaligned load returns 0.
//   Undefined: the misaligned low address bits are ignored and rsp_err
//              stays 0.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [31:0]         wdata_r;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [31:0]         rsp_rdata_r;
    logic                rsp_err_r;

    logic [31:0]         mem_r [DEPTH];
    logic [ADDR_W-3:0]   word_idx_s;
    logic [31:0]         rd_word_s;
    logic                misalign_s;
    logic [3:0]          wr_lanes_s;
    logic [31:0]         wr_data_s;
    logic [31:0]         rdata_s;
    logic                accept_s;

    // Byte-lane enables for a store, little-endian.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data replicated so every candidate lane carries the right bytes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Move the addressed byte/half to bit 0, then extend it.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lo,
                                                 input logic uns, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef DMEM_MISALIGN_ERR_EN
    // Halves need an even address; words need the low two bits clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction
`endif

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign accept_s   = req_valid && req_ready_r;
    assign word_idx_s = addr_r[ADDR_W-1:2];

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (NO_WAIT) begin
                        state_s = ST_ACCESS;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ACCESS;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // RAM-access datapath: lane enables, write data and extracted load data.
    always_comb begin
        rd_word_s = mem_r[word_idx_s];
        wr_data_s = store_data(size_r, wdata_r);
`ifdef DMEM_MISALIGN_ERR_EN
        misalign_s = is_misaligned(size_r, addr_r[1:0]);
`else
        misalign_s = 1'b0;
`endif
        if (state_r == ST_ACCESS && we_r && !misalign_s) begin
            wr_lanes_s = lane_mask(size_r, addr_r[1:0]);
        end else begin
            wr_lanes_s = 4'b0000;
        end
        if (we_r || misalign_s) begin
            rdata_s = 32'd0;
        end else begin
            rdata_s = load_extract(size_r, addr_r[1:0], uns_r, rd_word_s);
        end
    end

    // State, request latch and registered handshake/response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
            if (state_r == ST_IDLE && accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                size_r  <= req_size;
                uns_r   <= req_unsigned;
                wdata_r <= req_wdata;
            end
            if (state_r == ST_ACCESS) begin
                rsp_rdata_r <= rdata_s;
                rsp_err_r   <= misalign_s;
            end
        end
    end

    // RAM lane writes; contents are never reset, and a reset on the access
    // edge aborts the store.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lanes_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: four instances with WAIT_CYCLES = 0..3, a
// byte-array reference model, a directed vector table, and random traffic.
module tb_dmem_ctrl;

    localparam int NI = 4;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n        [NI];
    logic        req_valid    [NI];
    logic        req_ready    [NI];
    logic        req_we       [NI];
    logic [13:0] req_addr     [NI];
    logic [1:0]  req_size     [NI];
    logic        req_unsigned [NI];
    logic [31:0] req_wdata    [NI];
    logic        rsp_valid    [NI];
    logic        rsp_ready    [NI];
    logic [31:0] rsp_rdata    [NI];
    logic        rsp_err      [NI];

    int n_checks = 0;
    int n_fail   = 0;

    bit [7:0] mref [NI][16384];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            dmem_ctrl #(.ADDR_W(14), .WAIT_CYCLES(g)) u_dut (
                .clk(clk), .rst_n(rst_n[g]),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]),
                .req_we(req_we[g]), .req_addr(req_addr[g]), .req_size(req_size[g]),
                .req_unsigned(req_unsigned[g]), .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
            );
        end
    endgenerate

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the RAM is a byte array, and accesses are computed from
    // the size and alignment arithmetic.
    task automatic model(input int d, input bit we, input logic [13:0] a, input logic [1:0] sz,
                         input bit un, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er);
        int nb, ai, base;
        logic [31:0] v;
        ai   = int'(a);
        nb   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        er   = ERR_EN && ((ai % nb) != 0);
        base = ai - (ai % nb);
        rd   = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mref[d][base + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(mref[d][base + i]) << (8 * i));
                if (!un && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                rd = v;
            end
        end
    endtask

    // One full transaction on instance d, entered and left on a negedge.
    task automatic txn(input int d, input bit we, input logic [13:0] a, input logic [1:0] sz,
                       input bit un, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output bit er);
        int n;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready[d], 1'b1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_size[d] = sz;
        req_unsigned[d] = un; req_wdata[d] = wd;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wdata[d] = $urandom;
        req_addr[d]  = 14'($urandom);
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 64) begin
            check("req_ready_busy", req_ready[d], 1'b0);
            @(negedge clk);
            n++;
        end
        check("latency", n, 32'(2 + d));
        check("req_ready_resp", req_ready[d], 1'b0);
        rd = rsp_rdata[d];
        er = rsp_err[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid[d], 1'b1);
            check("hold_rdata", rsp_rdata[d], rd);
            check("hold_err", rsp_err[d], er);
            check("hold_req_ready", req_ready[d], 1'b0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_valid_drop", rsp_valid[d], 1'b0);
        check("req_ready_back", req_ready[d], 1'b1);
    endtask

    typedef struct {
        bit          we;
        logic [13:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] mask;
        bit          exp_err;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] rd, mrd;
        bit er, mer;
        logic [31:0] wd;

        vecs[0]  = '{1'b1, 14'h010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{1'b0, 14'h010, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{1'b1, 14'h011, 2'd0, 1'b0, 32'h1234565A, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[3]  = '{1'b0, 14'h010, 2'd2, 1'b0, 32'h0,        32'hDEAD5AEF, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{1'b0, 14'h013, 2'd0, 1'b0, 32'h0,        32'hFFFFFFDE, 32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{1'b0, 14'h013, 2'd0, 1'b1, 32'h0,        32'h000000DE, 32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{1'b1, 14'h022, 2'd1, 1'b0, 32'hABCD8001, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{1'b0, 14'h022, 2'd1, 1'b0, 32'h0,        32'hFFFF8001, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{1'b0, 14'h022, 2'd1, 1'b1, 32'h0,        32'h00008001, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{1'b0, 14'h020, 2'd2, 1'b0, 32'h0,        32'h80010000, 32'hFFFF0000, 1'b0};
        vecs[10] = '{1'b1, 14'h030, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[11] = '{1'b1, 14'h031, 2'd2, 1'b0, 32'h11223344, 32'h0,        32'hFFFFFFFF, ERR_EN};
        vecs[12] = '{1'b0, 14'h030, 2'd2, 1'b0, 32'h0,
                     ERR_EN ? 32'hCAFEF00D : 32'h11223344, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{1'b0, 14'h032, 2'd2, 1'b0, 32'h0,
                     ERR_EN ? 32'h0 : (ERR_EN ? 32'hCAFEF00D : 32'h11223344), 32'hFFFFFFFF, ERR_EN};
        vecs[14] = '{1'b0, 14'h033, 2'd1, 1'b0, 32'h0,
                     ERR_EN ? 32'h0 : 32'h00001122, 32'hFFFFFFFF, ERR_EN};
        vecs[15] = '{1'b1, 14'h034, 2'd3, 1'b0, 32'h01020384, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[16] = '{1'b0, 14'h034, 2'd3, 1'b0, 32'h0,        32'h01020384, 32'hFFFFFFFF, 1'b0};
        vecs[17] = '{1'b0, 14'h034, 2'd0, 1'b0, 32'h0,        32'hFFFFFF84, 32'hFFFFFFFF, 1'b0};

        for (int d = 0; d < NI; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 14'd0;
            req_size[d] = 2'd0; req_unsigned[d] = 1'b0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            check("rst_req_ready", req_ready[d], 1'b1);
            check("rst_rsp_valid", rsp_valid[d], 1'b0);
            check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            check("rst_rsp_err", rsp_err[d], 1'b0);
            rst_n[d] = 1'b1;
        end
        @(negedge clk);

        // Give every instance a known window 0x000..0x0FF.
        for (int d = 0; d < NI; d++) begin
            for (int w = 0; w < 64; w++) begin
                wd = $urandom;
                txn(d, 1'b1, 14'(w * 4), 2'd2, 1'b0, wd, 0, rd, er);
                model(d, 1'b1, 14'(w * 4), 2'd2, 1'b0, wd, mrd, mer);
                check("init_store_rdata", rd, 32'd0);
            end
        end

        // Directed table on the zero-wait instance.
        for (int i = 0; i < 18; i++) begin
            txn(0, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, i % 3, rd, er);
            model(0, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, mrd, mer);
            check($sformatf("vec%0d_rdata", i), rd & vecs[i].mask, vecs[i].exp_rdata & vecs[i].mask);
            check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
        end

        // Three wait states with the consumer stalling for five cycles.
        txn(3, 1'b1, 14'h050, 2'd2, 1'b0, 32'hA5A55A5A, 5, rd, er);
        model(3, 1'b1, 14'h050, 2'd2, 1'b0, 32'hA5A55A5A, mrd, mer);
        check("w3_store_rdata", rd, 32'd0);
        txn(3, 1'b0, 14'h052, 2'd1, 1'b0, 32'd0, 5, rd, er);
        model(3, 1'b0, 14'h052, 2'd1, 1'b0, 32'd0, mrd, mer);
        check("w3_load_rdata", rd, 32'hFFFFA5A5);
        check("w3_load_err", er, 1'b0);

        // Reset during WAIT of a store on the two-wait instance.
        model(2, 1'b0, 14'h040, 2'd2, 1'b0, 32'd0, mrd, mer);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 14'h040; req_size[2] = 2'd2;
        req_unsigned[2] = 1'b0; req_wdata[2] = ~mrd;
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid_in_rst", rsp_valid[2], 1'b0);
        check("abort_req_ready_in_rst", req_ready[2], 1'b1);
        rst_n[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_rsp_valid", rsp_valid[2], 1'b0);
            check("abort_req_ready", req_ready[2], 1'b1);
        end
        txn(2, 1'b0, 14'h040, 2'd2, 1'b0, 32'd0, 0, rd, er);
        check("abort_word_unchanged", rd, mrd);

        // Random traffic against the model on every instance.
        for (int d = 0; d < NI; d++) begin
            for (int t = 0; t < 40; t++) begin
                bit          we, un;
                logic [13:0] a;
                logic [1:0]  sz;
                int          hold;
                we   = 1'($urandom);
                un   = 1'($urandom);
                a    = 14'($urandom_range(0, 255));
                sz   = 2'($urandom);
                wd   = $urandom;
                hold = $urandom_range(0, 3);
                txn(d, we, a, sz, un, wd, hold, rd, er);
                model(d, we, a, sz, un, wd, mrd, mer);
                check($sformatf("rand_i%0d_rdata", d), rd, mrd);
                check($sformatf("rand_i%0d_err", d), er, mer);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
